// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute sequencer for register-register ALU instructions on a single-bus datapath.
// Latency: ALU op 6 cycles, MUL/DIV 7, MFHI/MFLO/NOP/illegal 4, plus one cycle per MemReady=0 cycle in T1.
// Backpressure: fetch holds in T1 until MemReady; Stop is honoured only at an instruction boundary.
//
// Ports:
//   Clock, reset          rising-edge clock, synchronous active-high reset
//   IR                    latched instruction word from the datapath
//   MemReady              memory read data valid for the current Read
//   Stop                  halt request, taken at the next instruction boundary
//   *out / *in            bus drive enables / register load enables
//   IncPC, Read           ALU increment-PC select, memory read / MDR mux select
//   ADD..NOT              ALU op strobes, at most one high
//   GPRin, GPRout         one-hot general register load / drive enables
//   Run                   low only in HALT
//   Illegal               one-cycle pulse when an undefined opcode reaches decode
//   State                 current state code
module alu_control_sequencer #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic [BITS-1:0]      IR,
  input  logic                 MemReady,
  input  logic                 Stop,
  output logic                 PCout,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 MDRout,
  output logic                 HIout,
  output logic                 LOout,
  output logic                 PCin,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 RZin,
  output logic                 MARin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 MDRin,
  output logic                 IncPC,
  output logic                 Read,
  output logic                 ADD,
  output logic                 SUB,
  output logic                 MUL,
  output logic                 DIV,
  output logic                 SHR,
  output logic                 SHL,
  output logic                 ROR,
  output logic                 ROL,
  output logic                 AND,
  output logic                 OR,
  output logic                 NEGATE,
  output logic                 NOT,
  output logic [REGISTERS-1:0] GPRin,
  output logic [REGISTERS-1:0] GPRout,
  output logic                 Run,
  output logic                 Illegal,
  output logic [3:0]           State
);

  localparam int RW     = $clog2(REGISTERS);
  localparam int RA_LSB = BITS - 5 - RW;
  localparam int RB_LSB = RA_LSB - RW;
  localparam int RC_LSB = RB_LSB - RW;

  localparam logic [REGISTERS-1:0] ONE = {{(REGISTERS-1){1'b0}}, 1'b1};

  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00100;
  localparam logic [4:0] OP_SHR    = 5'b00101;
  localparam logic [4:0] OP_SHL    = 5'b00110;
  localparam logic [4:0] OP_ROR    = 5'b00111;
  localparam logic [4:0] OP_ROL    = 5'b01000;
  localparam logic [4:0] OP_AND    = 5'b01001;
  localparam logic [4:0] OP_OR     = 5'b01010;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_NEGATE = 5'b10001;
  localparam logic [4:0] OP_NOT    = 5'b10010;
  localparam logic [4:0] OP_MFHI   = 5'b10110;
  localparam logic [4:0] OP_MFLO   = 5'b10111;
  localparam logic [4:0] OP_NOP    = 5'b11000;
  localparam logic [4:0] OP_HALT   = 5'b11001;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t state_q, state_d, boundary_next;

  logic [4:0]    opcode;
  logic [RW-1:0] ra, rb, rc;
  logic          unused_ir;

  assign opcode    = IR[BITS-1 -: 5];
  assign ra        = IR[RA_LSB +: RW];
  assign rb        = IR[RB_LSB +: RW];
  assign rc        = IR[RC_LSB +: RW];
  assign unused_ir = ^IR[RC_LSB-1:0];

  // Instruction class decode of the latched IR.
  logic is_alu, is_muldiv, is_unary, is_mfhi, is_mflo, is_nop, is_halt;

  always_comb begin
    is_alu    = 1'b0;
    is_muldiv = 1'b0;
    is_unary  = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: is_alu = 1'b1;
      OP_MUL, OP_DIV: begin
        is_alu    = 1'b1;
        is_muldiv = 1'b1;
      end
      OP_NEGATE, OP_NOT: begin
        is_alu   = 1'b1;
        is_unary = 1'b1;
      end
      OP_MFHI: is_mfhi = 1'b1;
      OP_MFLO: is_mflo = 1'b1;
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Where the last state of an instruction goes: Stop is only looked at here.
  assign boundary_next = Stop ? S_HALT : S_T0;

  always_ff @(posedge Clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign State = state_q;
  assign Run   = (state_q != S_HALT);

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    RYin     = 1'b0;
    RZin     = 1'b0;
    MARin    = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    MDRin    = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    ADD      = 1'b0;
    SUB      = 1'b0;
    MUL      = 1'b0;
    DIV      = 1'b0;
    SHR      = 1'b0;
    SHL      = 1'b0;
    ROR      = 1'b0;
    ROL      = 1'b0;
    AND      = 1'b0;
    OR       = 1'b0;
    NEGATE   = 1'b0;
    NOT      = 1'b0;
    GPRin    = '0;
    GPRout   = '0;
    Illegal  = 1'b0;

    case (state_q)
      S_IDLE: state_d = Stop ? S_HALT : S_T0;

      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        RZin    = 1'b1;
        state_d = S_T1;
      end

      // Z holds PC+1 for the whole wait; PC is loaded only on the exit
      // cycle so a stalled fetch cannot advance it more than once.
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (MemReady) begin
          PCin    = 1'b1;
          state_d = S_T2;
        end
      end

      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end

      S_T3: begin
        if (is_alu) begin
          GPRout  = ONE << rb;
          RYin    = 1'b1;
          state_d = S_T4;
        end else if (is_mfhi) begin
          HIout   = 1'b1;
          GPRin   = ONE << ra;
          state_d = boundary_next;
        end else if (is_mflo) begin
          LOout   = 1'b1;
          GPRin   = ONE << ra;
          state_d = boundary_next;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_nop) begin
          state_d = boundary_next;
        end else begin
          Illegal = 1'b1;
          state_d = boundary_next;
        end
      end

      // Unary ops take their operand straight from rb; RY is ignored.
      S_T4: begin
        RZin    = 1'b1;
        GPRout  = is_unary ? (ONE << rb) : (ONE << rc);
        state_d = S_T5;
        case (opcode)
          OP_ADD:    ADD    = 1'b1;
          OP_SUB:    SUB    = 1'b1;
          OP_SHR:    SHR    = 1'b1;
          OP_SHL:    SHL    = 1'b1;
          OP_ROR:    ROR    = 1'b1;
          OP_ROL:    ROL    = 1'b1;
          OP_AND:    AND    = 1'b1;
          OP_OR:     OR     = 1'b1;
          OP_MUL:    MUL    = 1'b1;
          OP_DIV:    DIV    = 1'b1;
          OP_NEGATE: NEGATE = 1'b1;
          OP_NOT:    NOT    = 1'b1;
          default:   ;
        endcase
      end

      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          GPRin   = ONE << ra;
          state_d = boundary_next;
        end
      end

      // High product word, or the remainder for DIV.
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = boundary_next;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Hardwired control unit that drives the single-bus `datapath` through fetch and execute for register-register ALU instructions. Each step is an explicit T-state: T0–T2 fetch, T3–T6 execute. It decodes the latched instruction word (`IRVal` from the datapath) and emits one-hot register-select and ALU-op strobes. It stalls fetch on a memory-ready handshake and supports halt and stop-at-boundary.

## Interface
- `BITS`, 32, datapath/instruction width
- `REGISTERS`, 16, number of GPRs; register fields are log2(REGISTERS)=4 bits
- `Clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `IR`  in  BITS  current instruction register contents
- `MemReady`  in  1  memory data valid for the current `Read`
- `Stop`  in  1  request to halt at the next instruction boundary
- `PCout, Zlowout, Zhighout, MDRout, HIout, LOout`  out  1 each  bus drive enables
- `PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin`  out  1 each  register load enables
- `IncPC, Read`  out  1 each  ALU increment-PC select, memory read/MDR mux select
- `ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT`  out  1 each  ALU op select, at most one high
- `GPRin, GPRout`  out  REGISTERS  one-hot GPR load and drive enables
- `Run`  out  1  high unless in HALT
- `Illegal`  out  1  one-cycle pulse on an undefined opcode
- `State`  out  4  current state code, for debug

## Operation
- Instruction fields:
  - opcode = `IR[31:27]`
  - ra = `IR[26:23]` (destination)
  - rb = `IR[22:19]`
  - rc = `IR[18:15]`
- Opcodes:
  - 00011 ADD, 00100 SUB, 00101 SHR, 00110 SHL, 00111 ROR, 01000 ROL, 01001 AND, 01010 OR
  - 01111 MUL, 10000 DIV, 10001 NEGATE, 10010 NOT
  - 10110 MFHI, 10111 MFLO, 11000 NOP, 11001 HALT
  - All others are illegal.
- States: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.
- Outputs are a Moore decode of state plus latched `IR`. Every output not listed for a state is 0.
- IDLE: all outputs 0. Next state is T0 unless `Stop`=1, which goes to HALT.
- T0: `PCout`, `MARin`, `IncPC`, `RZin`. Next T1.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - Stays in T1 while `MemReady`=0; all T1 outputs held.
  - `PCin` is asserted only in the exit cycle (`MemReady`=1) so PC increments exactly once.
  - Exits to T2 when `MemReady`=1.
- T2: `MDRout`, `IRin`. Next T3.
- T3 (decode on `IR`):
  - ALU ops: `GPRout[rb]`, `RYin` → T4
  - MFHI: `HIout`, `GPRin[ra]` → T0 (or HALT if `Stop`)
  - MFLO: `LOout`, `GPRin[ra]` → T0 (or HALT if `Stop`)
  - NOP: no outputs → T0 (or HALT if `Stop`)
  - HALT: → HALT
  - illegal: `Illegal`=1 → T0 (or HALT if `Stop`)
- T4: op strobe and `RZin`.
  - Binary ops drive `GPRout[rc]`.
  - NEGATE/NOT drive `GPRout[rb]`; RY contents are ignored.
  - Next T5.
- T5:
  - MUL/DIV: `Zlowout`, `LOin` → T6
  - Others: `Zlowout`, `GPRin[ra]` → T0 (or HALT if `Stop`)
- T6 (MUL/DIV only): `Zhighout`, `HIin` → T0 (or HALT if `Stop`). HI gets the high product word or the DIV remainder.
- HALT: all outputs 0, `Run`=0. Exit only by `reset`.

## Timing
- `reset` sampled high at a rising edge forces IDLE on that edge. All outputs are 0 while in IDLE, and `Run`=1.
- Reset mid-instruction abandons it with no further strobes. Register side effects already clocked remain.
- Latency with `MemReady` tied high:
  - ALU op: 6 cycles (T0–T5)
  - MUL/DIV: 7 cycles
  - MFHI/MFLO/NOP/illegal: 4 cycles
- Each cycle of `MemReady`=0 in T1 adds 1 cycle.
- `Stop` is sampled only in the final state of an instruction and in IDLE. `Stop` pulses at any other time are ignored.
- `IR` must be stable from the end of T2 through the instruction's last state. `IRin` guarantees this in the datapath.
- Register-select rules:
  - `GPRout` and the bus-drive enables are mutually exclusive in every state.
  - `GPRin`/`GPRout` have at most one bit set.
  - ra=rb=rc is legal; no special handling.

## Test plan
- Reset for 2 cycles, release, `MemReady`=1, `IR`=0x18918000 (ADD r1,r2,r3):
  - IDLE then T0..T5 on consecutive cycles
  - T3: `GPRout`=0x0004, `RYin`
  - T4: `GPRout`=0x0008, `ADD`, `RZin`
  - T5: `GPRin`=0x0002
  - next cycle T0
- `IR`=0x78228000 (MUL, rb=4, rc=5):
  - T4: `MUL`, `GPRout`=0x0020
  - T5: `LOin`
  - T6: `Zhighout`+`HIin`
  - `GPRin` never asserted
- `MemReady` low for 3 cycles in T1:
  - T1 held 4 cycles with `Read`/`MDRin` high
  - `PCin` high exactly once, in the exit cycle
  - `IRin` follows in T2
- `IR`=0xF8000000 (illegal):
  - `Illegal` high for 1 cycle in T3, no op strobes
  - returns to T0, total 4 cycles
- `IR`=0xC8000000 (HALT): `State`=8, `Run`=0, all strobes 0 for 20 cycles; `reset` returns to IDLE.
- `Stop` held high during an ADD: instruction completes through T5 (`GPRin` asserted), then HALT; a `Stop` pulse only in T2 is ignored.
